// File: rtl/dist_ram_loader.sv
// Streams words into consecutive addresses of a single-port distributed RAM,
// then reads the region back and compares additive checksums.
module dist_ram_loader #(
  parameter int AW = 6,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   len,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic [AW-1:0] ram_a,
  output logic [DW-1:0] ram_d,
  output logic          ram_we,
  input  logic [DW-1:0] ram_spo,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [DW-1:0] checksum
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WRITE  = 2'd1,
    S_VERIFY = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_base;
  logic [AW:0]   r_len;
  logic [AW:0]   r_off;
  logic [DW-1:0] r_wsum;
  logic [DW-1:0] r_rsum;
  logic [DW-1:0] r_checksum;
  logic          r_done;
  logic          r_error;

  logic          w_last;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_rsum_next;
  logic          w_in_write;
  logic          w_in_verify;

  assign w_in_write  = (r_state == S_WRITE);
  assign w_in_verify = (r_state == S_VERIFY);
  assign w_last      = (r_off == (r_len - (AW+1)'(1)));
  // AW-bit addition gives the modulo-depth wrap for free.
  assign w_addr      = r_base + r_off[AW-1:0];
  assign w_rsum_next = r_rsum + ram_spo;

  assign in_ready = w_in_write;
  assign ram_we   = w_in_write & in_valid;
  assign ram_a    = (w_in_write | w_in_verify) ? w_addr : '0;
  assign ram_d    = w_in_write ? in_data : '0;
  assign busy     = w_in_write | w_in_verify;
  assign done     = r_done;
  assign error    = r_error;
  assign checksum = r_checksum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_base     <= '0;
      r_len      <= '0;
      r_off      <= '0;
      r_wsum     <= '0;
      r_rsum     <= '0;
      r_checksum <= '0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_base <= base;
            r_len  <= len;
            r_off  <= '0;
            r_wsum <= '0;
            r_rsum <= '0;
            // An empty load has trivially matching checksums.
            if (len == '0) begin
              r_state    <= S_RESULT;
              r_done     <= 1'b1;
              r_checksum <= '0;
            end else begin
              r_state <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (in_valid) begin
            r_wsum <= r_wsum + in_data;
            if (w_last) begin
              r_off   <= '0;
              r_state <= S_VERIFY;
            end else begin
              r_off <= r_off + (AW+1)'(1);
            end
          end
        end
        S_VERIFY: begin
          r_rsum <= w_rsum_next;
          r_off  <= r_off + (AW+1)'(1);
          if (w_last) begin
            // Flags and checksum are registered so they are visible during RESULT.
            r_state    <= S_RESULT;
            r_checksum <= r_wsum;
            if (w_rsum_next == r_wsum) r_done  <= 1'b1;
            else                       r_error <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
